// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID->EX pipeline register with operand assembly. It sits directly behind the
// register-file read ports and:
//   - picks each source operand from x0 (hardwired zero), the writeback value
//     landing this very cycle, or the register-file read data;
//   - detects a load in EX whose destination is read by the instruction in ID
//     (load-use hazard), stalls ID and drops exactly one bubble into EX;
//   - kills the EX slot on a mispredict flush and holds it under backpressure,
//     refreshing held operands if writeback updates their source registers;
//   - counts inserted load-use bubbles in a saturating counter.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   id_*_i                   decoded instruction currently in ID
//   rf_rs1_data_i/rs2        register-file read data for id_rs1/rs2_addr_i
//   wb_rd_wren_i/addr/data   writeback port, same cycle as the regfile write
//   ex_flush_i               mispredict flush from EX
//   ex_stall_i               EX cannot accept a new instruction
//   id_stall_o               hold PC/IF/ID this cycle (combinational)
//   ex_*_o                   registered EX-stage copy of the ID instruction
//   bubble_cnt_o             saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  id_valid_i,
    input  logic [DATA_WIDTH-1:0] id_pc_i,
    input  logic [ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [ADDR_WIDTH-1:0] id_rd_addr_i,
    input  logic                  id_rd_wren_i,
    input  logic                  id_is_load_i,
    input  logic [DATA_WIDTH-1:0] id_imm_i,
    input  logic [CTRL_WIDTH-1:0] id_ctrl_i,
    input  logic                  id_pred_taken_i,

    input  logic [DATA_WIDTH-1:0] rf_rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rf_rs2_data_i,

    input  logic                  wb_rd_wren_i,
    input  logic [ADDR_WIDTH-1:0] wb_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_rd_data_i,

    input  logic                  ex_flush_i,
    input  logic                  ex_stall_i,

    output logic                  id_stall_o,

    output logic                  ex_valid_o,
    output logic [DATA_WIDTH-1:0] ex_pc_o,
    output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
    output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
    output logic [ADDR_WIDTH-1:0] ex_rs1_addr_o,
    output logic [ADDR_WIDTH-1:0] ex_rs2_addr_o,
    output logic [ADDR_WIDTH-1:0] ex_rd_addr_o,
    output logic                  ex_rd_wren_o,
    output logic                  ex_is_load_o,
    output logic [DATA_WIDTH-1:0] ex_imm_o,
    output logic [CTRL_WIDTH-1:0] ex_ctrl_o,
    output logic                  ex_pred_taken_o,

    output logic [CNT_WIDTH-1:0]  bubble_cnt_o
);

    // One EX slot. An all-zero value is a bubble.
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [ADDR_WIDTH-1:0] rs1_addr;
        logic [ADDR_WIDTH-1:0] rs2_addr;
        logic [ADDR_WIDTH-1:0] rd_addr;
        logic                  rd_wren;
        logic                  is_load;
        logic [DATA_WIDTH-1:0] imm;
        logic [CTRL_WIDTH-1:0] ctrl;
        logic                  pred_taken;
    } ex_slot_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    ex_slot_t              ex_q;
    ex_slot_t              id_slot;
    logic [CNT_WIDTH-1:0]  bubble_cnt_q;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic                  ex_load_pending;
    logic                  rs1_needs_load;
    logic                  rs2_needs_load;
    logic                  load_use;
    logic                  refresh_rs1;
    logic                  refresh_rs2;

    // The register file does not forward its own write, so a value being
    // written back this cycle must be taken from the WB port directly.
    // x0 is forced to zero no matter what the file or WB carry.
    function automatic logic [DATA_WIDTH-1:0] select_operand(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] rf_data
    );
        logic [DATA_WIDTH-1:0] val;
        val = rf_data;
        if (addr == '0) begin
            val = '0;
        end else if (wb_rd_wren_i && (wb_rd_addr_i == addr)) begin
            val = wb_rd_data_i;
        end
        return val;
    endfunction

    always_comb begin
        rs1_val = select_operand(id_rs1_addr_i, rf_rs1_data_i);
        rs2_val = select_operand(id_rs2_addr_i, rf_rs2_data_i);
    end

    // A load in EX only produces its data at the end of MEM, which is too
    // late for the instruction directly behind it, so that consumer waits.
    always_comb begin
        ex_load_pending = ex_q.valid && ex_q.is_load && ex_q.rd_wren &&
                          (ex_q.rd_addr != '0);
        rs1_needs_load  = id_rs1_used_i && (id_rs1_addr_i == ex_q.rd_addr);
        rs2_needs_load  = id_rs2_used_i && (id_rs2_addr_i == ex_q.rd_addr);
        load_use        = id_valid_i && ex_load_pending &&
                          (rs1_needs_load || rs2_needs_load);
        // Flush clears both the hazard source and the reason to hold.
        id_stall_o      = !ex_flush_i && (ex_stall_i || load_use);
    end

    // While EX is held its operands were captured earlier; a writeback to the
    // same register in the meantime would otherwise leave them stale.
    always_comb begin
        refresh_rs1 = wb_rd_wren_i && (ex_q.rs1_addr != '0) &&
                      (wb_rd_addr_i == ex_q.rs1_addr);
        refresh_rs2 = wb_rd_wren_i && (ex_q.rs2_addr != '0) &&
                      (wb_rd_addr_i == ex_q.rs2_addr);
    end

    always_comb begin
        id_slot = '0;
        if (id_valid_i) begin
            id_slot.valid      = 1'b1;
            id_slot.pc         = id_pc_i;
            id_slot.rs1_data   = rs1_val;
            id_slot.rs2_data   = rs2_val;
            id_slot.rs1_addr   = id_rs1_addr_i;
            id_slot.rs2_addr   = id_rs2_addr_i;
            id_slot.rd_addr    = id_rd_addr_i;
            id_slot.rd_wren    = id_rd_wren_i;
            id_slot.is_load    = id_is_load_i;
            id_slot.imm        = id_imm_i;
            id_slot.ctrl       = id_ctrl_i;
            id_slot.pred_taken = id_pred_taken_i;
        end
    end

    // Priority: reset, flush, hold, load-use bubble, normal advance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else if (ex_flush_i) begin
            ex_q <= '0;
        end else if (ex_stall_i) begin
            if (refresh_rs1) begin
                ex_q.rs1_data <= wb_rd_data_i;
            end
            if (refresh_rs2) begin
                ex_q.rs2_data <= wb_rd_data_i;
            end
        end else if (load_use) begin
            ex_q <= '0;
            if (bubble_cnt_q != CNT_MAX) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_WIDTH'(1);
            end
        end else begin
            ex_q <= id_slot;
        end
    end

    assign ex_valid_o      = ex_q.valid;
    assign ex_pc_o         = ex_q.pc;
    assign ex_rs1_data_o   = ex_q.rs1_data;
    assign ex_rs2_data_o   = ex_q.rs2_data;
    assign ex_rs1_addr_o   = ex_q.rs1_addr;
    assign ex_rs2_addr_o   = ex_q.rs2_addr;
    assign ex_rd_addr_o    = ex_q.rd_addr;
    assign ex_rd_wren_o    = ex_q.rd_wren;
    assign ex_is_load_o    = ex_q.is_load;
    assign ex_imm_o        = ex_q.imm;
    assign ex_ctrl_o       = ex_q.ctrl;
    assign ex_pred_taken_o = ex_q.pred_taken;
    assign bubble_cnt_o    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_operand_stage
//
// Drives the ID->EX stage with directed scenarios and random traffic. A
// register-file array plus an architectural view of it supply operand values;
// the expected EX slot and bubble count are tracked per cycle.
// ---------------------------------------------------------------------------
module tb_id_ex_operand_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;
    localparam int NW = 4;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          rst_i;
    logic          id_valid_i;
    logic [DW-1:0] id_pc_i;
    logic [AW-1:0] id_rs1_addr_i;
    logic [AW-1:0] id_rs2_addr_i;
    logic          id_rs1_used_i;
    logic          id_rs2_used_i;
    logic [AW-1:0] id_rd_addr_i;
    logic          id_rd_wren_i;
    logic          id_is_load_i;
    logic [DW-1:0] id_imm_i;
    logic [CW-1:0] id_ctrl_i;
    logic          id_pred_taken_i;
    logic [DW-1:0] rf_rs1_data_i;
    logic [DW-1:0] rf_rs2_data_i;
    logic          wb_rd_wren_i;
    logic [AW-1:0] wb_rd_addr_i;
    logic [DW-1:0] wb_rd_data_i;
    logic          ex_flush_i;
    logic          ex_stall_i;
    logic          id_stall_o;
    logic          ex_valid_o;
    logic [DW-1:0] ex_pc_o;
    logic [DW-1:0] ex_rs1_data_o;
    logic [DW-1:0] ex_rs2_data_o;
    logic [AW-1:0] ex_rs1_addr_o;
    logic [AW-1:0] ex_rs2_addr_o;
    logic [AW-1:0] ex_rd_addr_o;
    logic          ex_rd_wren_o;
    logic          ex_is_load_o;
    logic [DW-1:0] ex_imm_o;
    logic [CW-1:0] ex_ctrl_o;
    logic          ex_pred_taken_o;
    logic [NW-1:0] bubble_cnt_o;

    id_ex_operand_stage #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rd_addr_i(id_rd_addr_i), .id_rd_wren_i(id_rd_wren_i),
        .id_is_load_i(id_is_load_i), .id_imm_i(id_imm_i), .id_ctrl_i(id_ctrl_i),
        .id_pred_taken_i(id_pred_taken_i),
        .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
        .wb_rd_wren_i(wb_rd_wren_i), .wb_rd_addr_i(wb_rd_addr_i),
        .wb_rd_data_i(wb_rd_data_i),
        .ex_flush_i(ex_flush_i), .ex_stall_i(ex_stall_i),
        .id_stall_o(id_stall_o),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_rs1_addr_o(ex_rs1_addr_o), .ex_rs2_addr_o(ex_rs2_addr_o),
        .ex_rd_addr_o(ex_rd_addr_o), .ex_rd_wren_o(ex_rd_wren_o),
        .ex_is_load_o(ex_is_load_o), .ex_imm_o(ex_imm_o), .ex_ctrl_o(ex_ctrl_o),
        .ex_pred_taken_o(ex_pred_taken_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [DW-1:0] rs1_data;
        logic [DW-1:0] rs2_data;
        logic [AW-1:0] rs1_addr;
        logic [AW-1:0] rs2_addr;
        logic [AW-1:0] rd_addr;
        logic          rd_wren;
        logic          is_load;
        logic [DW-1:0] imm;
        logic [CW-1:0] ctrl;
        logic          pred_taken;
    } instr_t;

    // Raw register-file contents (x0 may hold junk; the stage must ignore it).
    logic [DW-1:0] rf [32];
    instr_t        expEx;
    int            expCnt;
    int            checks   = 0;
    int            failures = 0;
    string         phase    = "init";

    assign rf_rs1_data_i = rf[id_rs1_addr_i];
    assign rf_rs2_data_i = rf[id_rs2_addr_i];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s/%s: got=%0h expected=%0h", phase, tag, got, exp);
        end
    endtask

    // Architectural value of a register as seen by an instruction reading it
    // in the same cycle that writeback commits: the write has already happened.
    function automatic logic [DW-1:0] archValue(input logic [AW-1:0] a);
        logic [DW-1:0] regs [32];
        regs = rf;
        if (wb_rd_wren_i) regs[wb_rd_addr_i] = wb_rd_data_i;
        return (a == '0) ? '0 : regs[a];
    endfunction

    task automatic setIdle();
        rst_i = 1'b0; id_valid_i = 1'b0; id_pc_i = '0;
        id_rs1_addr_i = '0; id_rs2_addr_i = '0;
        id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0;
        id_rd_addr_i = '0; id_rd_wren_i = 1'b0; id_is_load_i = 1'b0;
        id_imm_i = '0; id_ctrl_i = '0; id_pred_taken_i = 1'b0;
        wb_rd_wren_i = 1'b0; wb_rd_addr_i = '0; wb_rd_data_i = '0;
        ex_flush_i = 1'b0; ex_stall_i = 1'b0;
    endtask

    task automatic setInstr(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                            input logic use1, input logic use2,
                            input logic [AW-1:0] rd, input logic isLoad);
        id_valid_i = 1'b1; id_pc_i = $urandom;
        id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
        id_rs1_used_i = use1; id_rs2_used_i = use2;
        id_rd_addr_i = rd; id_rd_wren_i = 1'b1; id_is_load_i = isLoad;
        id_imm_i = $urandom; id_ctrl_i = CW'($urandom); id_pred_taken_i = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus();
        rst_i           = ($urandom_range(0, 63) == 0);
        ex_flush_i      = ($urandom_range(0, 9) == 0);
        ex_stall_i      = ($urandom_range(0, 4) == 0);
        id_valid_i      = ($urandom_range(0, 3) != 0);
        id_pc_i         = $urandom;
        id_rs1_addr_i   = AW'($urandom_range(0, 7));
        id_rs2_addr_i   = AW'($urandom_range(0, 7));
        id_rs1_used_i   = 1'($urandom_range(0, 1));
        id_rs2_used_i   = 1'($urandom_range(0, 1));
        id_rd_addr_i    = AW'($urandom_range(0, 7));
        id_rd_wren_i    = ($urandom_range(0, 3) != 0);
        id_is_load_i    = ($urandom_range(0, 2) == 0);
        id_imm_i        = $urandom;
        id_ctrl_i       = CW'($urandom);
        id_pred_taken_i = 1'($urandom_range(0, 1));
        wb_rd_wren_i    = 1'($urandom_range(0, 1));
        wb_rd_addr_i    = AW'($urandom_range(0, 7));
        wb_rd_data_i    = $urandom;
    endtask

    task automatic checkEx();
        checkOutput("ex_valid",      64'(ex_valid_o),      64'(expEx.valid));
        checkOutput("ex_pc",         64'(ex_pc_o),         64'(expEx.pc));
        checkOutput("ex_rs1_data",   64'(ex_rs1_data_o),   64'(expEx.rs1_data));
        checkOutput("ex_rs2_data",   64'(ex_rs2_data_o),   64'(expEx.rs2_data));
        checkOutput("ex_rs1_addr",   64'(ex_rs1_addr_o),   64'(expEx.rs1_addr));
        checkOutput("ex_rs2_addr",   64'(ex_rs2_addr_o),   64'(expEx.rs2_addr));
        checkOutput("ex_rd_addr",    64'(ex_rd_addr_o),    64'(expEx.rd_addr));
        checkOutput("ex_rd_wren",    64'(ex_rd_wren_o),    64'(expEx.rd_wren));
        checkOutput("ex_is_load",    64'(ex_is_load_o),    64'(expEx.is_load));
        checkOutput("ex_imm",        64'(ex_imm_o),        64'(expEx.imm));
        checkOutput("ex_ctrl",       64'(ex_ctrl_o),       64'(expEx.ctrl));
        checkOutput("ex_pred_taken", 64'(ex_pred_taken_o), 64'(expEx.pred_taken));
        checkOutput("bubble_cnt",    64'(bubble_cnt_o),    64'(expCnt));
    endtask

    // One clock: check the stall decision, predict the next EX slot, clock,
    // commit writeback into the regfile array and compare.
    task automatic stepCycle();
        instr_t nxt;
        int     ncnt;
        logic   hazard;
        logic   expStall;
        #1;
        hazard = id_valid_i && expEx.valid && expEx.is_load && expEx.rd_wren &&
                 (expEx.rd_addr != '0) &&
                 ((id_rs1_used_i && id_rs1_addr_i == expEx.rd_addr) ||
                  (id_rs2_used_i && id_rs2_addr_i == expEx.rd_addr));
        expStall = !ex_flush_i && (ex_stall_i || hazard);
        checkOutput("id_stall", 64'(id_stall_o), 64'(expStall));

        nxt  = expEx;
        ncnt = expCnt;
        if (rst_i) begin
            nxt = '0; ncnt = 0;
        end else if (ex_flush_i) begin
            nxt = '0;
        end else if (ex_stall_i) begin
            if (wb_rd_wren_i && wb_rd_addr_i != '0) begin
                if (wb_rd_addr_i == expEx.rs1_addr) nxt.rs1_data = wb_rd_data_i;
                if (wb_rd_addr_i == expEx.rs2_addr) nxt.rs2_data = wb_rd_data_i;
            end
        end else if (hazard) begin
            nxt = '0;
            if (ncnt < (1 << NW) - 1) ncnt++;
        end else if (id_valid_i) begin
            nxt = '{valid: 1'b1, pc: id_pc_i,
                    rs1_data: archValue(id_rs1_addr_i), rs2_data: archValue(id_rs2_addr_i),
                    rs1_addr: id_rs1_addr_i, rs2_addr: id_rs2_addr_i, rd_addr: id_rd_addr_i,
                    rd_wren: id_rd_wren_i, is_load: id_is_load_i, imm: id_imm_i,
                    ctrl: id_ctrl_i, pred_taken: id_pred_taken_i};
        end else begin
            nxt = '0;
        end

        @(posedge clk_i);
        #1;
        if (wb_rd_wren_i) rf[wb_rd_addr_i] = wb_rd_data_i;
        expEx  = nxt;
        expCnt = ncnt;
        checkEx();
    endtask

    logic [DW-1:0] savedPc;

    initial begin
        expEx  = '0;
        expCnt = 0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hBAD0_0000;

        phase = "reset";
        setIdle(); rst_i = 1'b1;
        stepCycle();

        // WB bypass to a live register and suppression for x0.
        phase = "bypass";
        setIdle(); rf[5] = '0;
        setInstr(5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b0);
        wb_rd_wren_i = 1'b1; wb_rd_addr_i = 5'd5; wb_rd_data_i = 32'hDEADBEEF;
        stepCycle();
        checkOutput("rs1_wb_bypass", 64'(ex_rs1_data_o), 64'h0000_0000_DEAD_BEEF);
        setIdle();
        setInstr(5'd0, 5'd6, 1'b1, 1'b1, 5'd8, 1'b0);
        wb_rd_wren_i = 1'b1; wb_rd_addr_i = 5'd0; wb_rd_data_i = 32'h1234;
        stepCycle();
        checkOutput("rs1_x0_zero", 64'(ex_rs1_data_o), 64'h0);

        // lw x7 followed by add x1,x2,x7.
        phase = "load_use";
        setIdle(); setInstr(5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1);
        stepCycle();
        setIdle(); setInstr(5'd2, 5'd7, 1'b1, 1'b1, 5'd1, 1'b0);
        #1 checkOutput("lu_stall", 64'(id_stall_o), 64'h1);
        stepCycle();
        checkOutput("lu_bubble_valid", 64'(ex_valid_o), 64'h0);
        checkOutput("lu_bubble_cnt", 64'(bubble_cnt_o), 64'h1);
        wb_rd_wren_i = 1'b1; wb_rd_addr_i = 5'd7; wb_rd_data_i = 32'hCAFE0007;
        stepCycle();
        checkOutput("lu_consumer_valid", 64'(ex_valid_o), 64'h1);
        checkOutput("lu_consumer_rs2", 64'(ex_rs2_data_o), 64'h0000_0000_CAFE_0007);

        // Flush beats stall and load-use.
        phase = "flush";
        setIdle(); setInstr(5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1);
        stepCycle();
        setIdle(); setInstr(5'd7, 5'd3, 1'b1, 1'b0, 5'd1, 1'b0);
        ex_flush_i = 1'b1; ex_stall_i = 1'b1;
        #1 checkOutput("flush_no_stall", 64'(id_stall_o), 64'h0);
        stepCycle();
        checkOutput("flush_valid", 64'(ex_valid_o), 64'h0);
        checkOutput("flush_cnt_kept", 64'(bubble_cnt_o), 64'h1);

        // Three-cycle hold with a writeback to the held rs1 in the middle.
        phase = "hold";
        setIdle(); setInstr(5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b0);
        stepCycle();
        savedPc = ex_pc_o;
        setIdle(); setInstr(5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b0); ex_stall_i = 1'b1;
        stepCycle();
        wb_rd_wren_i = 1'b1; wb_rd_addr_i = 5'd3; wb_rd_data_i = 32'h55;
        stepCycle();
        checkOutput("hold_refresh_c2", 64'(ex_rs1_data_o), 64'h55);
        wb_rd_wren_i = 1'b0;
        stepCycle();
        checkOutput("hold_refresh_c3", 64'(ex_rs1_data_o), 64'h55);
        checkOutput("hold_pc", 64'(ex_pc_o), 64'(savedPc));

        phase = "random";
        for (int n = 0; n < 1500; n++) begin
            applyStimulus();
            stepCycle();
        end

        // Reset after activity clears everything.
        phase = "reset_mid";
        setIdle(); setInstr(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1);
        stepCycle();
        rst_i = 1'b1;
        stepCycle();
        checkOutput("rst_valid", 64'(ex_valid_o), 64'h0);
        checkOutput("rst_cnt", 64'(bubble_cnt_o), 64'h0);

        // Twenty load-use hazards saturate the 4-bit counter.
        phase = "saturate";
        for (int k = 0; k < 20; k++) begin
            setIdle(); setInstr(5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1);
            stepCycle();
            setIdle(); setInstr(5'd9, 5'd2, 1'b1, 1'b1, 5'd4, 1'b0);
            stepCycle();
            if (k == 14) checkOutput("sat_reach", 64'(bubble_cnt_o), 64'hF);
        end
        checkOutput("sat_hold", 64'(bubble_cnt_o), 64'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
